// File: rtl/fifo_ctrl_if.sv
// Producer/consumer-facing signal bundle of the FIFO pointer and flag controller.
// The requester side drives wr/rd; the controller side drives RAM addressing and status.
interface fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  wr;
    logic                  rd;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr, rd,
        input  wr_en, wr_addr, rd_addr, count, full, empty, almost_full, overflow, underflow
    );

    modport slave (
        input  wr, rd,
        output wr_en, wr_addr, rd_addr, count, full, empty, almost_full, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl.sv
// FIFO pointer/occupancy controller: owns read and write pointers of a dual-port RAM,
// keeps an up/down occupancy count and registered full/empty/almost-full and sticky error flags.
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12
) (
    input  logic        clk,
    input  logic        reset,
    fifo_ctrl_if.slave  bus
);
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   ZERO_C  = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic                  full_r;
    logic                  empty_r;
    logic                  af_r;
    logic                  ovf_r;
    logic                  udf_r;

    logic                  push_ok_s;
    logic                  pop_ok_s;
    logic [ADDR_WIDTH:0]   count_nxt_s;
    logic [ADDR_WIDTH-1:0] wr_ptr_nxt_s;
    logic [ADDR_WIDTH-1:0] rd_ptr_nxt_s;
    logic                  full_nxt_s;
    logic                  empty_nxt_s;
    logic                  af_nxt_s;
    logic                  ovf_nxt_s;
    logic                  udf_nxt_s;

    // Acceptance, next pointers, next occupancy and next flags from the registered flags.
    always_comb begin
        push_ok_s    = bus.wr & ~full_r;
        pop_ok_s     = bus.rd & ~empty_r;
        count_nxt_s  = count_r;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;

        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase

        // Pointers wrap naturally at the power-of-two depth.
        if (push_ok_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_ok_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        full_nxt_s  = (count_nxt_s == DEPTH_C);
        empty_nxt_s = (count_nxt_s == ZERO_C);
        af_nxt_s    = (count_nxt_s >= AF_C);
        ovf_nxt_s   = ovf_r | (bus.wr & full_r);
        udf_nxt_s   = udf_r | (bus.rd & empty_r);
    end

    // State registers; flags follow the next-state count so they always agree with count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r <= {ADDR_WIDTH{1'b0}};
            count_r  <= ZERO_C;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            af_r     <= 1'b0;
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            full_r   <= full_nxt_s;
            empty_r  <= empty_nxt_s;
            af_r     <= af_nxt_s;
            ovf_r    <= ovf_nxt_s;
            udf_r    <= udf_nxt_s;
        end
    end

    // The write strobe must fall in the same cycle full is seen, so it stays combinational.
    assign bus.wr_en       = bus.wr & ~full_r;
    assign bus.wr_addr     = wr_ptr_r;
    assign bus.rd_addr     = rd_ptr_r;
    assign bus.count       = count_r;
    assign bus.full        = full_r;
    assign bus.empty       = empty_r;
    assign bus.almost_full = af_r;
    assign bus.overflow    = ovf_r;
    assign bus.underflow   = udf_r;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: a driver pushes expected post-edge state into a queue,
// a monitor pops and compares after every clock edge, plus hand-computed checkpoints.
module tb_fifo_ctrl;
    logic clk;
    logic reset;

    fifo_ctrl_if #(.ADDR_WIDTH(4)) bus ();

    fifo_ctrl #(.ADDR_WIDTH(4), .AF_LEVEL(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0] count;
        logic [3:0] wa;
        logic [3:0] ra;
        logic       full;
        logic       empty;
        logic       af;
        logic       ovf;
        logic       udf;
        logic       wr_en;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    int m_cnt;
    int m_wa;
    int m_ra;
    bit m_ovf;
    bit m_udf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t sample();
        snap_t s;
        s.count = bus.count;
        s.wa    = bus.wr_addr;
        s.ra    = bus.rd_addr;
        s.full  = bus.full;
        s.empty = bus.empty;
        s.af    = bus.almost_full;
        s.ovf   = bus.overflow;
        s.udf   = bus.underflow;
        s.wr_en = bus.wr_en;
        return s;
    endfunction

    function automatic string fmt(snap_t s);
        return $sformatf("cnt=%0d wa=%0d ra=%0d full=%0b empty=%0b af=%0b ovf=%0b udf=%0b wr_en=%0b",
                         s.count, s.wa, s.ra, s.full, s.empty, s.af, s.ovf, s.udf, s.wr_en);
    endfunction

    task automatic compare_snap(string name, snap_t act, snap_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {%s} want {%s}", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic dcheck(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Monitor: after every edge the DUT presents a new state; compare against the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) compare_snap("scoreboard", sample(), exp_q.pop_front());
        end
    end

    // Apply one cycle of requests and queue the state expected after the edge.
    task automatic step(bit w, bit r);
        snap_t e;
        bit    push_ok;
        bit    pop_ok;
        @(negedge clk);
        bus.wr = w;
        bus.rd = r;
        push_ok = w && (m_cnt < 16);
        pop_ok  = r && (m_cnt > 0);
        if (w && m_cnt == 16) m_ovf = 1'b1;
        if (r && m_cnt == 0)  m_udf = 1'b1;
        if (push_ok) begin
            m_cnt++;
            m_wa = (m_wa + 1) % 16;
        end
        if (pop_ok) begin
            m_cnt--;
            m_ra = (m_ra + 1) % 16;
        end
        e.count = 5'(m_cnt);
        e.wa    = 4'(m_wa);
        e.ra    = 4'(m_ra);
        e.full  = (m_cnt == 16);
        e.empty = (m_cnt == 0);
        e.af    = (m_cnt >= 12);
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        e.wr_en = w && (m_cnt != 16);
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_wa  = 0;
        m_ra  = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // Watchdog so the run always ends even if something stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        snap_t rst_exp;
        int    wa0;
        int    ra0;
        rst_exp = '{count: 5'd0, wa: 4'd0, ra: 4'd0, full: 1'b0, empty: 1'b1,
                    af: 1'b0, ovf: 1'b0, udf: 1'b0, wr_en: 1'b0};
        model_reset();
        reset  = 1'b1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        #3;
        compare_snap("reset_state", sample(), rst_exp);
        @(negedge clk);
        reset = 1'b0;

        // Fill: almost_full after 12th push, full and wrapped write pointer after 16th.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0);
            dcheck($sformatf("af_after_push%0d", i), int'(bus.almost_full), (i >= 12) ? 1 : 0);
        end
        dcheck("fill_count", int'(bus.count), 16);
        dcheck("fill_full", int'(bus.full), 1);
        dcheck("fill_wr_addr", int'(bus.wr_addr), 0);
        dcheck("fill_rd_addr", int'(bus.rd_addr), 0);

        // Push attempts while full are rejected and set overflow.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            dcheck("ovf_wr_en", int'(bus.wr_en), 0);
            dcheck("ovf_count", int'(bus.count), 16);
            dcheck("ovf_wr_addr", int'(bus.wr_addr), 0);
            dcheck("ovf_flag", int'(bus.overflow), 1);
        end

        // Drain: rd_addr walks through every slot and wraps.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1);
            dcheck($sformatf("drain_rd_addr%0d", i), int'(bus.rd_addr), (i + 1) % 16);
        end
        dcheck("drain_empty", int'(bus.empty), 1);
        dcheck("drain_count", int'(bus.count), 0);
        step(1'b0, 1'b1);
        dcheck("udf_flag", int'(bus.underflow), 1);
        dcheck("udf_count", int'(bus.count), 0);
        dcheck("ovf_sticky", int'(bus.overflow), 1);

        // Five entries, then 20 cycles of simultaneous push and pop.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        wa0 = int'(bus.wr_addr);
        ra0 = int'(bus.rd_addr);
        dcheck("pre_both_wa", wa0, 5);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
        dcheck("both_count", int'(bus.count), 5);
        dcheck("both_wa", int'(bus.wr_addr), (wa0 + 4) % 16);
        dcheck("both_ra", int'(bus.rd_addr), (ra0 + 4) % 16);
        dcheck("both_empty", int'(bus.empty), 0);
        dcheck("both_full", int'(bus.full), 0);

        // Simultaneous request while empty: only the push is taken.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        dcheck("empty_both_count", int'(bus.count), 1);
        dcheck("empty_both_wa", int'(bus.wr_addr), 10);
        dcheck("empty_both_ra", int'(bus.rd_addr), 9);

        // Simultaneous request while full: only the pop is taken.
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
        dcheck("refill_full", int'(bus.full), 1);
        step(1'b1, 1'b1);
        dcheck("full_both_count", int'(bus.count), 15);
        dcheck("full_both_ra", int'(bus.rd_addr), 10);
        dcheck("full_both_wa", int'(bus.wr_addr), 9);
        dcheck("full_both_fullflag", int'(bus.full), 0);

        // Count at 9 with both errors set, then reset between edges.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
        dcheck("pre_reset_count", int'(bus.count), 9);
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        compare_snap("async_reset", sample(), rst_exp);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(1'b1, 1'b0);
        dcheck("post_reset_count", int'(bus.count), 1);
        dcheck("post_reset_wa", int'(bus.wr_addr), 1);

        @(negedge clk);
        bus.wr = 1'b0;
        dcheck("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller for the FIFO. It owns both ends of the queue: it advances the write pointer on accepted pushes and the read pointer on accepted pops. It tracks occupancy with an up/down count and produces registered full, empty and almost-full flags. Sticky error flags record any rejected push or pop. It drives the address and write-enable ports of the dual-port RAM and sits between the producer and consumer logic and that RAM.

## Interface
Parameters:
- ADDR_WIDTH, default 4. Pointer width. FIFO depth is 2**ADDR_WIDTH entries.
- AF_LEVEL, default 12. Occupancy at or above which almost_full asserts. Legal range is 1 to 2**ADDR_WIDTH.

Ports:
- clk, input, 1 bit. Single clock. All state updates on posedge.
- reset, input, 1 bit. Asynchronous, active-high. Clears all state immediately, independent of clk.
- wr, input, 1 bit. Push request from the producer for this cycle.
- rd, input, 1 bit. Pop request from the consumer for this cycle.
- wr_en, output, 1 bit. RAM write strobe. Combinational: wr & ~full.
- wr_addr, output, ADDR_WIDTH bits. RAM write address. Registered write pointer.
- rd_addr, output, ADDR_WIDTH bits. RAM read address. Registered read pointer; points at the oldest entry.
- count, output, ADDR_WIDTH+1 bits. Current occupancy, 0 to 2**ADDR_WIDTH.
- full, output, 1 bit. Registered. High when count equals 2**ADDR_WIDTH.
- empty, output, 1 bit. Registered. High when count equals 0.
- almost_full, output, 1 bit. Registered. High when count is at least AF_LEVEL.
- overflow, output, 1 bit. Sticky. Set by a push attempted while full.
- underflow, output, 1 bit. Sticky. Set by a pop attempted while empty.

## Operation
- Accepted push: push_ok = wr & ~full.
- Accepted pop: pop_ok = rd & ~empty.
- Both use the flag values registered at the start of the cycle.
- On push_ok, wr_addr increments by 1 at the clock edge.
- On pop_ok, rd_addr increments by 1 at the clock edge.
- Pointers wrap modulo 2**ADDR_WIDTH with no special case: 2**ADDR_WIDTH-1 goes to 0.
- count update at each edge:
  - push_ok only: count+1.
  - pop_ok only: count-1.
  - both, or neither: count unchanged.
- count never exceeds 2**ADDR_WIDTH and never goes below 0, because the acceptance rules guarantee it.
- full, empty and almost_full are registered from the next-state count. They are therefore always consistent with count in the same cycle.
- Simultaneous rd and wr:
  - While empty: the push is accepted and the pop is rejected. underflow sets. Next state is count=1, empty=0.
  - While full: the pop is accepted and the push is rejected. overflow sets. Next state is count = depth-1, full=0.
  - Otherwise: both are accepted, count holds, and both pointers advance.
- A rejected request leaves pointers and count unchanged.
- overflow and underflow stay high until reset. No other input clears them.
- wr_en is the only combinational output. It must drop in the same cycle that full is high.
- The RAM writes at wr_addr on the clock edge where wr_en is high. RAM read data at rd_addr is the head entry; this block does not register RAM data.

## Timing
- Reset values: wr_addr=0, rd_addr=0, count=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0.
- wr_en is 0 during reset while wr is low. wr_en is wr & ~full, so it is not forced low by reset.
- Reset asserted mid-operation: all state clears asynchronously. Requests in the cycle reset releases are ignored. The first accepted push or pop is on the first posedge with reset low.
- Latency from a request edge to updated count, flags and pointers is 1 cycle.
- Push into an empty FIFO at edge N: empty=0 after edge N. The consumer may pop in cycle N+1.
- Pop of the last entry at edge N: empty=1 after edge N.
- Push of the last free entry at edge N: full=1 after edge N. wr_en is 0 from cycle N+1 on.
- Throughput is one push and one pop per cycle.
- No internal pipeline stalls and no output handshake beyond the flags.

## Test plan
- Reset, then push 16 times with ADDR_WIDTH=4 and AF_LEVEL=12:
  - almost_full rises after the 12th edge.
  - full=1, count=16 and wr_addr=0 (wrapped) after the 16th edge.
  - rd_addr stays 0.
- Full, then wr=1 for 3 cycles: wr_en=0, count stays 16, wr_addr unchanged, overflow=1 and stays 1 afterward.
- Full, then 16 pops:
  - rd_addr steps 0 to 15, then wraps to 0.
  - empty=1 and count=0 after the 16th edge.
  - One extra rd sets underflow=1 and count stays 0.
- Count at 5, rd=wr=1 for 20 cycles:
  - count holds at 5.
  - Both pointers advance by 20 mod 16 = 4.
  - Flags unchanged.
- Corner simultaneous cases:
  - Empty with rd=wr=1: count=1, wr_addr+1, rd_addr unchanged, underflow=1.
  - Full with rd=wr=1: count=15, rd_addr+1, wr_addr unchanged, overflow=1.
- Count at 9 with both error flags set, then assert reset between clock edges:
  - All outputs reach reset values before the next posedge.
  - After release, a push gives count=1, wr_addr=1.
